// File: rtl/sales_pkg.sv
// Shared definitions for the sales ledger.
//
// Holds the ledger FSM state encoding and the default widths and
// report-hold time. The top module and its testbench both import this
// package so they agree on the same values.
package sales_pkg;

  // Default width of one sale amount, in yuan.
  localparam int DEF_AMT_W       = 8;
  // Default width of the accumulated sales total.
  localparam int DEF_TOT_W       = 16;
  // Default width of the sale counter.
  localparam int DEF_CNT_W       = 10;
  // Default number of cycles the report stays valid.
  localparam int DEF_SHOW_CYCLES = 100000000;

  // IDLE: waiting for a sale, a view request or a clear.
  // ADD : one-cycle accumulate of the sale accepted in IDLE.
  // SHOW: report held valid for a fixed number of cycles.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SHOW = 2'd2
  } state_t;

endpackage : sales_pkg

// File: rtl/sat_add.sv
// Unsigned saturating adder.
//
// Ports:
//   a   in  W  first operand
//   b   in  W  second operand
//   sum out W  a + b, clamped to all-ones when the true sum overflows W bits
//
// Purely combinational. The ledger uses one instance for the running total
// and another for the sale counter.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // One extra bit catches the carry out. When it is set, the real sum
  // cannot be represented, so the result sticks at the largest value.
  logic [W:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
    if (full_sum[W]) begin
      sum = '1;
    end else begin
      sum = full_sum[W-1:0];
    end
  end

endmodule : sat_add

// File: rtl/sales_ledger.sv
// Sales ledger: accumulates completed sales and reports the total on request.
//
// Ports:
//   clk          in  1      system clock, all state updates on its rising edge
//   rst          in  1      synchronous active-high reset
//   sale_valid   in  1      a completed sale is offered
//   sale_amount  in  AMT_W  amount of the offered sale
//   sale_ready   out 1      ledger accepts a sale this cycle (combinational)
//   view_req     in  1      admin view request level; a rising edge asks for a report
//   clear_req    in  1      admin request to zero the ledger (honoured in IDLE only)
//   view_valid   out 1      rpt_total / rpt_count are valid
//   rpt_total    out TOT_W  snapshot of the accumulated total
//   rpt_count    out CNT_W  snapshot of the number of sales
//
// An accepted sale costs one ADD cycle. During that cycle the registered
// amount goes into the total and the counter increments. Both saturate
// at all-ones.
// A view edge is remembered in a pending flag. The next IDLE cycle with
// no accepted sale takes the snapshot, so a sale arriving with the request
// is already in the report. The report is held for SHOW_CYCLES cycles. No
// sale can enter during that window.
module sales_ledger
  import sales_pkg::*;
#(
  parameter int AMT_W       = DEF_AMT_W,
  parameter int TOT_W       = DEF_TOT_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SHOW_CYCLES = DEF_SHOW_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sale_valid,
  input  logic [AMT_W-1:0] sale_amount,
  output logic             sale_ready,
  input  logic             view_req,
  input  logic             clear_req,
  output logic             view_valid,
  output logic [TOT_W-1:0] rpt_total,
  output logic [CNT_W-1:0] rpt_count
);

  // The SHOW counter loads SHOW_CYCLES-1 and counts down to zero. That is
  // SHOW_CYCLES cycles in total, so it only needs to hold SHOW_CYCLES-1.
  localparam int SC_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SC_W-1:0] SHOW_LOAD = SC_W'(SHOW_CYCLES - 1);

  state_t           state;
  state_t           state_next;

  logic [AMT_W-1:0] amt_reg;
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] total_sum;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_sum;
  logic [SC_W-1:0]  show_cnt;

  logic             pending;
  logic             view_q;
  logic             view_edge;
  logic             accept;
  logic             do_clear;
  logic             start_show;
  logic             show_done;

  // Handshake and request decode. A clear in IDLE blocks the sale offered
  // in the same cycle, so ready drops whenever clear_req is high.
  // A snapshot starts only if neither a sale nor a clear claims this IDLE
  // cycle.
  always_comb begin
    sale_ready = (state == IDLE) && !clear_req;
    accept     = sale_valid && sale_ready;
    do_clear   = (state == IDLE) && clear_req;
    view_edge  = view_req && !view_q;
    start_show = (state == IDLE) && pending && !accept && !clear_req;
    show_done  = (show_cnt == '0);
  end

  // Saturating accumulate of the amount latched at acceptance.
  sat_add #(
    .W(TOT_W)
  ) u_total_add (
    .a  (total),
    .b  (TOT_W'(amt_reg)),
    .sum(total_sum)
  );

  // Saturating sale counter increment.
  sat_add #(
    .W(CNT_W)
  ) u_count_add (
    .a  (count),
    .b  (CNT_W'(1)),
    .sum(count_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A sale takes precedence over a pending view. ADD
  // always falls back to IDLE, which is where the deferred view is picked
  // up.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ADD;
        end else if (start_show) begin
          state_next = SHOW;
        end
      end
      ADD: begin
        state_next = IDLE;
      end
      SHOW: begin
        if (show_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ledger registers: amount capture, total and count, and the clear.
  // clear_req is only decoded in IDLE, so a clear raised during ADD or
  // SHOW has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      amt_reg <= '0;
      total   <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        amt_reg <= sale_amount;
      end
      if (do_clear) begin
        total <= '0;
        count <= '0;
      end else if (state == ADD) begin
        total <= total_sum;
        count <= count_sum;
      end
    end
  end

  // View request tracking. The registered copy of view_req turns the level
  // into an edge. Edges arriving in SHOW are dropped, because a report is
  // already on display. Starting a snapshot consumes the pending request,
  // and a clear discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      view_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      view_q <= view_req;
      if (do_clear || start_show) begin
        pending <= 1'b0;
      end else if (view_edge && (state != SHOW)) begin
        pending <= 1'b1;
      end
    end
  end

  // Report snapshot and hold timer. The snapshot is taken on the IDLE->SHOW
  // edge, so view_valid rises together with the SHOW state. The snapshot
  // registers are left alone afterwards and keep the last report.
  always_ff @(posedge clk) begin
    if (rst) begin
      show_cnt   <= '0;
      view_valid <= 1'b0;
      rpt_total  <= '0;
      rpt_count  <= '0;
    end else begin
      if (start_show) begin
        show_cnt   <= SHOW_LOAD;
        view_valid <= 1'b1;
        rpt_total  <= total;
        rpt_count  <= count;
      end else if (state == SHOW) begin
        if (show_done) begin
          view_valid <= 1'b0;
        end else begin
          show_cnt <= show_cnt - 1'b1;
        end
      end
    end
  end

endmodule : sales_ledger

// File: doc/sales_ledger.md
SALES_LEDGER -- requirements
Module: sales_ledger

Interface
REQ-001 Parameter AMT_W, default 8: width of one sale amount, in yuan.
REQ-002 Parameter TOT_W, default 16: width of the accumulated sales total.
REQ-003 Parameter CNT_W, default 10: width of the sale counter.
REQ-004 Parameter SHOW_CYCLES, default 100000000: number of cycles the report is held valid.
REQ-005 The module SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 sale_valid  in  1  a completed sale is offered.
REQ-009 sale_amount  in  AMT_W  amount of the offered sale.
REQ-010 sale_ready  out  1  ledger can accept a sale this cycle.
REQ-011 view_req  in  1  admin "view total sales" request level; the request is the rising edge.
REQ-012 clear_req  in  1  admin request to zero the ledger.
REQ-013 view_valid  out  1  report outputs are valid.
REQ-014 rpt_total  out  TOT_W  snapshot of the accumulated total.
REQ-015 rpt_count  out  CNT_W  snapshot of the sale count.

Function
REQ-016 FSM states SHALL be IDLE, ADD and SHOW.
REQ-017 sale_ready SHALL equal (state==IDLE && !clear_req) and SHALL be combinational.
REQ-018 A sale is accepted on a cycle where sale_valid && sale_ready; the FSM then enters ADD for exactly one cycle.
REQ-019 In ADD, the total SHALL add the registered amount with saturation at all-ones, and the count SHALL increment with saturation at all-ones; the FSM then returns to IDLE.
REQ-020 An accepted sale's effect SHALL be visible in the internal total 2 cycles after acceptance.
REQ-021 The view_req rising edge SHALL be detected against a registered copy of view_req and SHALL set a pending flag in any state except SHOW.
REQ-022 In IDLE with a pending view and no sale accepted, the FSM SHALL enter SHOW, load rpt_total and rpt_count from the internal registers, clear pending, and assert view_valid from the next cycle.
REQ-023 Simultaneous sale acceptance and view edge: the sale SHALL win, and the view SHALL be serviced after ADD, so the report includes that sale.
REQ-024 SHOW SHALL last exactly SHOW_CYCLES cycles, timed by a down-counter.
REQ-025 In SHOW, view_valid SHALL be 1, sale_ready SHALL be 0, and view edges SHALL be ignored; the FSM then returns to IDLE with view_valid 0.
REQ-026 clear_req in IDLE SHALL zero the total, the count and pending, and SHALL take priority over a simultaneous sale, which is not accepted.
REQ-027 clear_req in ADD or SHOW SHALL be ignored.
REQ-028 rpt_total and rpt_count SHALL hold their last snapshot outside SHOW.

Reset
REQ-029 On rst: state IDLE, total 0, count 0, pending 0, SHOW counter 0, view_valid 0, rpt_total 0, rpt_count 0, and the registered view_req copy 0.
REQ-030 rst SHALL override every other input in any state, including mid-ADD and mid-SHOW.
REQ-031 sale_ready SHALL be 1 on the first cycle after rst deasserts, unless clear_req is high.

Structure
REQ-032 The state encoding and the default widths SHALL be in the shared package sales_pkg.
REQ-033 The saturating adder SHALL be a single sub-module, sat_add.
REQ-034 Everything else SHALL be in one file.

Verification
REQ-035 Sales of 5, 10 and 3, then a view edge -> view_valid for SHOW_CYCLES cycles with rpt_total=18 and rpt_count=3.
REQ-036 TOT_W=8: sales of 200 and 100 -> rpt_total=255 (saturated), rpt_count=2.
REQ-037 A sale of 7 and a view edge on the same cycle, from a zero ledger -> ADD, then SHOW with rpt_total=7.
REQ-038 A sale offered during SHOW -> sale_ready=0 and no change to the total until SHOW ends; the sale is accepted on the first cycle back in IDLE.
REQ-039 clear_req and sale_valid(9) together in IDLE -> total=0 and count=0, the sale is not accepted; a following view reports 0/0.
REQ-040 rst asserted mid-SHOW -> view_valid=0, rpt_total=0 and state IDLE on the next cycle.
